// File: rtl/core_trace_monitor.sv
// core_trace_monitor: debug monitor that sits beside the core.
// It logs each retired {pc, ir} into a circular trace buffer, counts cycles
// spent in RUN and the retirements it logs, and requests a halt when an
// enabled PC breakpoint channel matches a retiring pc.
// Ports:
//   clk, rst          clock, synchronous active-low reset
//   en, clear         monitor enable, synchronous clear of trace/counters
//   valid, pc, ir     retirement stream from the core
//   bp_wr, bp_idx,
//   bp_addr, bp_en    breakpoint channel write port
//   resume            leave HALT
//   halt, halt_idx    halt request and the channel that caused it
//   cycle_cnt,
//   instr_cnt         RUN cycle counter, logged retirement counter
//   count, overflow   valid trace entries (saturating), sticky overwrite flag
//   rd_idx            trace read index, 0 = most recent
//   rd_pc, rd_ir      selected entry (combinational, 0 beyond count)
module core_trace_monitor #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned IR_W  = 32,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned NBP   = 4,
    parameter int unsigned CNT_W = 32,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned BW   = (NBP > 1) ? $clog2(NBP) : 1,
    localparam int unsigned CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clear,
    input  logic             valid,
    input  logic [XLEN-1:0]  pc,
    input  logic [IR_W-1:0]  ir,
    input  logic             bp_wr,
    input  logic [BW-1:0]    bp_idx,
    input  logic [XLEN-1:0]  bp_addr,
    input  logic             bp_en,
    input  logic             resume,
    output logic             halt,
    output logic [BW-1:0]    halt_idx,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt,
    output logic [CW-1:0]    count,
    output logic             overflow,
    input  logic [AW-1:0]    rd_idx,
    output logic [XLEN-1:0]  rd_pc,
    output logic [IR_W-1:0]  rd_ir
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HALT = 2'd2;

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [AW-1:0]   wptr;
    logic            skip;
    logic [NBP-1:0]  bp_en_r;
    logic [XLEN-1:0] bp_addr_r [NBP];
    logic [XLEN-1:0] buf_pc    [DEPTH];
    logic [IR_W-1:0] buf_ir    [DEPTH];

    logic            hit;
    logic [BW-1:0]   hit_idx;
    logic            do_log;
    logic [AW-1:0]   rd_ptr;

    // Breakpoint match against pre-write channel values; lowest channel wins
    // because the descending loop lets the lowest index assign last.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = int'(NBP) - 1; k >= 0; k--) begin
            if ((state == RUN) && valid && !skip && bp_en_r[k] &&
                (pc == bp_addr_r[k])) begin
                hit     = 1'b1;
                hit_idx = BW'(k);
            end
        end
    end

    // A retirement is logged only in RUN and never on a clearing edge.
    assign do_log = (state == RUN) && valid && !clear;

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = RUN;
            RUN: begin
                if (hit)      state_nxt = HALT;
                else if (!en) state_nxt = IDLE;
            end
            HALT:    if (resume) state_nxt = en ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State, halt status, skip flag, breakpoint enables and counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            halt      <= 1'b0;
            halt_idx  <= '0;
            skip      <= 1'b0;
            bp_en_r   <= '0;
            cycle_cnt <= '0;
            instr_cnt <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            wptr      <= '0;
        end else begin
            state <= state_nxt;
            halt  <= (state_nxt == HALT);
            if (hit) halt_idx <= hit_idx;

            // skip shields the first retirement after resume from matching
            if ((state == HALT) && (state_nxt == RUN)) skip <= 1'b1;
            else if (state_nxt == IDLE)                skip <= 1'b0;
            else if ((state == RUN) && valid)          skip <= 1'b0;

            if (bp_wr && (32'(bp_idx) < NBP)) bp_en_r[bp_idx] <= bp_en;

            if (clear) begin
                cycle_cnt <= '0;
                instr_cnt <= '0;
                count     <= '0;
                overflow  <= 1'b0;
                wptr      <= '0;
            end else if (state == RUN) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
                if (valid) begin
                    instr_cnt <= instr_cnt + CNT_W'(1);
                    wptr      <= wptr + AW'(1);
                    if (count == CW'(DEPTH)) overflow <= 1'b1;
                    else                     count    <= count + CW'(1);
                end
            end
        end
    end

    // Breakpoint addresses and trace storage carry no reset.
    always_ff @(posedge clk) begin
        if (rst && bp_wr && (32'(bp_idx) < NBP)) bp_addr_r[bp_idx] <= bp_addr;
        if (rst && do_log) begin
            buf_pc[wptr] <= pc;
            buf_ir[wptr] <= ir;
        end
    end

    // Readout walks backwards from the newest entry; unwritten slots read 0.
    assign rd_ptr = wptr - AW'(1) - rd_idx;

    always_comb begin
        rd_pc = '0;
        rd_ir = '0;
        if ({1'b0, rd_idx} < count) begin
            rd_pc = buf_pc[rd_ptr];
            rd_ir = buf_ir[rd_ptr];
        end
    end

endmodule
